// File: rtl/dino_pixel_gen.sv
// dino_pixel_gen: 3-stage pixel pipeline behind the VGA timing controller.
// Optional ground line: define DINO_GROUND_LINE_EN.
module dino_pixel_gen #(
   parameter int          SPR_W        = 32,
   parameter int          SPR_H        = 32,
   parameter logic [11:0] BG_COLOR     = 12'hFFF,
   parameter logic [11:0] KEY_COLOR    = 12'hF0F,
   parameter int          GROUND_Y     = 400,
   parameter logic [11:0] GROUND_COLOR = 12'h555
) (
   input  logic        pclk,
   input  logic        reset,
   input  logic [9:0]  h_cnt,
   input  logic [9:0]  v_cnt,
   input  logic        valid,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic [9:0]  spr_x,
   input  logic [9:0]  spr_y,
   output logic [9:0]  rom_addr,
   input  logic [11:0] rom_data,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        hsync,
   output logic        vsync,
   output logic        frame_tick
);

   // frame latch state
   logic        vs_prev;
   logic        vs_fall;
   logic [9:0]  x_lat;
   logic [9:0]  y_lat;
   logic        pos_ok;

   // stage 1 registers
   logic [9:0]  s1_h;
   logic [9:0]  s1_v;
   logic        s1_valid;
   logic        s1_hs;
   logic        s1_vs;

   // stage 2 combinational terms
   logic [9:0]  dx;
   logic [9:0]  dy;
   logic        in_x;
   logic        in_y;
   logic        hit;
   logic [9:0]  hit_addr;

   // stage 2 registers
   logic        s2_hit;
   logic        s2_valid;
   logic        s2_hs;
   logic        s2_vs;

   // stage 3
   logic [11:0] pix;
   logic [11:0] rgb;
   logic        s3_hs;
   logic        s3_vs;

   assign vs_fall = vs_prev & ~vsync_in;

   // Capture the sprite position on the vsync falling edge so a frame never tears.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         vs_prev    <= 1'b1;
         x_lat      <= 10'd0;
         y_lat      <= 10'd0;
         pos_ok     <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         vs_prev    <= vsync_in;
         frame_tick <= vs_fall;
         if (vs_fall) begin
            x_lat  <= spr_x;
            y_lat  <= spr_y;
            pos_ok <= 1'b1;
         end
      end
   end

   // Stage 1: register the controller counters and raw syncs.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         s1_h     <= 10'd0;
         s1_v     <= 10'd0;
         s1_valid <= 1'b0;
         s1_hs    <= 1'b1;
         s1_vs    <= 1'b1;
      end else begin
         s1_h     <= h_cnt;
         s1_v     <= v_cnt;
         s1_valid <= valid;
         s1_hs    <= hsync_in;
         s1_vs    <= vsync_in;
      end
   end

   // Sprite window test on 11-bit bounds so the right edge clips instead of wrapping.
   always_comb begin
      dx   = s1_h - x_lat;
      dy   = s1_v - y_lat;
      in_x = ({1'b0, s1_h} >= {1'b0, x_lat}) &&
             ({1'b0, s1_h} < ({1'b0, x_lat} + 11'(SPR_W)));
      in_y = ({1'b0, s1_v} >= {1'b0, y_lat}) &&
             ({1'b0, s1_v} < ({1'b0, y_lat} + 11'(SPR_H)));
      hit  = pos_ok & s1_valid & in_x & in_y;
      hit_addr = 10'(({10'd0, dy} * 20'(SPR_W)) + {10'd0, dx});
   end

   // Stage 2: issue the ROM address and carry the hit and sync bits.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         rom_addr <= 10'd0;
         s2_hit   <= 1'b0;
         s2_valid <= 1'b0;
         s2_hs    <= 1'b1;
         s2_vs    <= 1'b1;
      end else begin
         rom_addr <= hit ? hit_addr : 10'd0;
         s2_hit   <= hit;
         s2_valid <= s1_valid;
         s2_hs    <= s1_hs;
         s2_vs    <= s1_vs;
      end
   end

`ifdef DINO_GROUND_LINE_EN
   logic s2_gnd;

   // Ground flag travels beside the hit bit so both reach colour select together.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         s2_gnd <= 1'b0;
      end else begin
         s2_gnd <= s1_valid & (s1_v == 10'(GROUND_Y));
      end
   end

   // Colour select: blanking, opaque sprite, ground line, background.
   always_comb begin
      pix = 12'h000;
      if (s2_valid) begin
         if (s2_hit && (rom_data != KEY_COLOR)) begin
            pix = rom_data;
         end else if (s2_gnd) begin
            pix = GROUND_COLOR;
         end else begin
            pix = BG_COLOR;
         end
      end
   end
`else
   logic [21:0] unused_ground;
   assign unused_ground = {10'(GROUND_Y), GROUND_COLOR};

   // Colour select: blanking, opaque sprite, background.
   always_comb begin
      pix = 12'h000;
      if (s2_valid) begin
         if (s2_hit && (rom_data != KEY_COLOR)) begin
            pix = rom_data;
         end else begin
            pix = BG_COLOR;
         end
      end
   end
`endif

   // Stage 3: register colour and the last sync tap for the pins.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         rgb   <= 12'h000;
         s3_hs <= 1'b1;
         s3_vs <= 1'b1;
      end else begin
         rgb   <= pix;
         s3_hs <= s2_hs;
         s3_vs <= s2_vs;
      end
   end

   assign vga_r = rgb[11:8];
   assign vga_g = rgb[7:4];
   assign vga_b = rgb[3:0];
   assign hsync = s3_hs;
   assign vsync = s3_vs;

endmodule

// File: tb/tb_dino_pixel_gen.sv
// Bench for dino_pixel_gen: directed plus randomised pixels
// against a frame-level reference model of the sprite renderer.
`timescale 1ns/1ps
module tb_dino_pixel_gen;
   localparam int N = 16384;
   localparam logic [11:0] KEY = 12'hF0F;
`ifdef DINO_GROUND_LINE_EN
   localparam bit GND_ON = 1'b1;
`else
   localparam bit GND_ON = 1'b0;
`endif

   logic        pclk = 1'b0;
   logic        reset = 1'b0;
   logic [9:0]  h_cnt = 10'd0;
   logic [9:0]  v_cnt = 10'd0;
   logic        valid = 1'b0;
   logic        hsync_in = 1'b1;
   logic        vsync_in = 1'b1;
   logic [9:0]  spr_x = 10'd0;
   logic [9:0]  spr_y = 10'd0;
   logic [9:0]  rom_addr;
   logic [11:0] rom_data;
   logic [3:0]  vga_r;
   logic [3:0]  vga_g;
   logic [3:0]  vga_b;
   logic        hsync;
   logic        vsync;
   logic        frame_tick;

   logic [11:0] rom_tbl [1024];
   assign rom_data = rom_tbl[rom_addr];

   always #20 pclk = ~pclk;

   dino_pixel_gen dut (
      .pclk(pclk),
      .reset(reset),
      .h_cnt(h_cnt),
      .v_cnt(v_cnt),
      .valid(valid),
      .hsync_in(hsync_in),
      .vsync_in(vsync_in),
      .spr_x(spr_x),
      .spr_y(spr_y),
      .rom_addr(rom_addr),
      .rom_data(rom_data),
      .vga_r(vga_r),
      .vga_g(vga_g),
      .vga_b(vga_b),
      .hsync(hsync),
      .vsync(vsync),
      .frame_tick(frame_tick)
   );

   int checks = 0;
   int failures = 0;

   // reference model state
   int m_x = 0;
   int m_y = 0;
   bit m_ok = 1'b0;
   bit m_prev_vs = 1'b1;
   int cur_sx = 0;
   int cur_sy = 0;

   // expected outputs indexed by input cycle
   logic [11:0] e_pix [N];
   logic [9:0]  e_addr [N];
   bit          e_hs [N];
   bit          e_vs [N];
   bit          e_fall [N];
   int n = 0;
   int base = 1 << 30;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, n);
      end
   endtask

   function automatic void model_px(input int h, input int v, input bit val,
                                    output logic [11:0] pix,
                                    output logic [9:0] addr);
      bit hit;
      int a;
      a = 0;
      pix = 12'h000;
      addr = 10'd0;
      hit = val && m_ok && h >= m_x && h < m_x + 32 &&
            v >= m_y && v < m_y + 32;
      if (hit) begin
         a = (v - m_y) * 32 + (h - m_x);
         addr = 10'(a);
      end
      if (!val) pix = 12'h000;
      else if (hit && rom_tbl[a] != KEY) pix = rom_tbl[a];
      else if (GND_ON && v == 400) pix = 12'h555;
      else pix = 12'hFFF;
   endfunction

   task automatic step(input int h, input int v, input bit val,
                       input bit hs, input bit vs);
      bit fall;
      logic [11:0] pix;
      logic [9:0] addr;
      @(negedge pclk);
      n++;
      if (n - 3 >= base) begin
         chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e_pix[n-3]));
         chk("hsync", 32'(hsync), 32'(e_hs[n-3]));
         chk("vsync", 32'(vsync), 32'(e_vs[n-3]));
      end
      if (n - 2 >= base)
         chk("rom_addr", 32'(rom_addr), 32'(e_addr[n-2]));
      if (n - 1 >= base)
         chk("frame_tick", 32'(frame_tick), 32'(e_fall[n-1]));
      h_cnt = 10'(h);
      v_cnt = 10'(v);
      valid = val;
      hsync_in = hs;
      vsync_in = vs;
      spr_x = 10'(cur_sx);
      spr_y = 10'(cur_sy);
      fall = m_prev_vs && !vs;
      m_prev_vs = vs;
      if (fall) begin
         m_x = cur_sx;
         m_y = cur_sy;
         m_ok = 1'b1;
      end
      model_px(h, v, val, pix, addr);
      e_pix[n] = pix;
      e_addr[n] = addr;
      e_hs[n] = hs;
      e_vs[n] = vs;
      e_fall[n] = fall;
   endtask

   task automatic idle(input int cnt);
      for (int i = 0; i < cnt; i++) step(0, 0, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic vblank();
      idle(2);
      for (int i = 0; i < 4; i++) step(0, 0, 1'b0, 1'b1, 1'b0);
      idle(2);
   endtask

   task automatic row(input int v, input int h0, input int h1);
      for (int h = h0; h <= h1; h++) step(h, v, 1'b1, 1'b1, 1'b1);
   endtask

   task automatic reset_mid(input int h);
      @(negedge pclk);
      n++;
      h_cnt = 10'(h);
      v_cnt = 10'd300;
      valid = 1'b1;
      hsync_in = 1'b0;
      vsync_in = 1'b1;
      #5;
      reset = 1'b1;
      base = 1 << 30;
      #1;
      chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
      chk("rst_hsync", 32'(hsync), 32'h1);
      chk("rst_vsync", 32'(vsync), 32'h1);
      chk("rst_tick", 32'(frame_tick), 32'h0);
      chk("rst_addr", 32'(rom_addr), 32'h0);
      @(negedge pclk);
      n++;
      chk("rst_hold_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
      h_cnt = 10'd0;
      v_cnt = 10'd0;
      valid = 1'b0;
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      m_ok = 1'b0;
      m_prev_vs = 1'b1;
      reset = 1'b0;
      base = n + 1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) rom_tbl[i] = 12'(i);
      cur_sx = 100;
      cur_sy = 300;
      reset_mid(100);

      // nothing drawn before the first vsync fall
      idle(3);
      row(300, 95, 140);

      // first latch at (100,300)
      vblank();
      step(100, 300, 1'b1, 1'b1, 1'b1);
      step(131, 331, 1'b1, 1'b1, 1'b1);
      step(132, 300, 1'b1, 1'b1, 1'b1);
      step(99, 300, 1'b1, 1'b1, 1'b1);
      row(305, 96, 136);

      // request moves mid-frame, takes effect next frame
      cur_sx = 200;
      row(240, 95, 140);
      row(310, 95, 240);
      vblank();
      row(310, 95, 240);

      // right-edge clip, no wrap into next line
      cur_sx = 620;
      cur_sy = 100;
      vblank();
      row(100, 600, 639);
      row(101, 0, 20);

      // transparent word over the ground row
      idle(4);
      rom_tbl[(400 - 390) * 32 + 5] = KEY;
      rom_tbl[(400 - 390) * 32 + 6] = KEY;
      cur_sx = 300;
      cur_sy = 390;
      vblank();
      row(400, 290, 340);
      row(399, 300, 310);
      row(401, 300, 310);

      // randomised frames
      for (int f = 0; f < 6; f++) begin
         idle(4);
         for (int i = 0; i < 1024; i++)
            rom_tbl[i] = ($urandom_range(0, 7) == 0) ? KEY : 12'($urandom);
         cur_sx = $urandom_range(0, 660);
         cur_sy = $urandom_range(0, 500);
         vblank();
         for (int i = 0; i < 600; i++) begin
            int h;
            int v;
            bit val;
            bit hs;
            val = $urandom_range(0, 7) != 0;
            hs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
               h = m_x - 4 + $urandom_range(0, 40);
               v = m_y - 2 + $urandom_range(0, 36);
            end else begin
               h = $urandom_range(0, 639);
               v = $urandom_range(0, 479);
            end
            if ($urandom_range(0, 15) == 0) v = 400;
            if (h < 0) h = 0;
            if (h > 639) h = 639;
            if (v < 0) v = 0;
            if (v > 479) v = 479;
            if (!val) begin
               h = 0;
               v = 0;
            end
            if ($urandom_range(0, 99) == 0) cur_sx = $urandom_range(0, 660);
            step(h, v, val, hs, 1'b1);
         end
      end

      // reset mid-line, then no sprite until the next vsync fall
      idle(4);
      for (int i = 0; i < 1024; i++) rom_tbl[i] = 12'(i);
      cur_sx = 100;
      cur_sy = 300;
      reset_mid(100);
      idle(2);
      row(300, 98, 134);
      vblank();
      row(300, 98, 134);
      idle(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dino_pixel_gen.md
# dino_pixel_gen

Pixel generation stage directly downstream of the VGA timing controller. Consumes the display counters, `valid` and the raw sync outputs; renders the background, an optional ground line and one 32×32 RGB444 sprite (the dino) from an external synchronous ROM. Outputs registered RGB plus syncs delayed to match, ready for the VGA pins. Sprite position is latched once per frame so the image never tears mid-frame.

## Interface
- `SPR_W`, 32: sprite width in pixels, power of two.
- `SPR_H`, 32: sprite height in pixels.
- `BG_COLOR`, 12'hFFF: background colour, RGB444.
- `KEY_COLOR`, 12'hF0F: ROM value treated as transparent.
- `GROUND_Y`, 400: screen line of the ground line.
- `GROUND_COLOR`, 12'h555: ground line colour.

- `pclk` in 1: pixel clock, 25 MHz.
- `reset` in 1: asynchronous, active-high.
- `h_cnt` in 10: pixel column, 0 outside the active area.
- `v_cnt` in 10: pixel row, 0 outside the active area.
- `valid` in 1: active-area flag.
- `hsync_in` in 1: raw hsync, active-low.
- `vsync_in` in 1: raw vsync, active-low.
- `spr_x` in 10: requested sprite left column, from game logic.
- `spr_y` in 10: requested sprite top row.
- `rom_addr` out 10: sprite ROM address, row-major `row*SPR_W+col`.
- `rom_data` in 12: ROM word; one-cycle read latency.
- `vga_r`, `vga_g`, `vga_b` out 4 each: pixel colour.
- `hsync`, `vsync` out 1 each: syncs delayed to align with RGB.
- `frame_tick` out 1: one-cycle pulse per frame at position latch.

## Operation
- Frame latch: registered copy of `vsync_in`; falling edge (prev 1, cur 0) latches `spr_x`/`spr_y` into `x_lat`/`y_lat`, sets `pos_ok`, and pulses `frame_tick` on the following cycle. Value present on the latch cycle is the one used.
- Until the first latch after reset, `pos_ok`=0 and no sprite pixels are drawn.
- Stage 1 (S1): register `h_cnt`, `v_cnt`, `valid`, syncs.
- Stage 2 (S2): hit = `pos_ok` & valid & h∈[x_lat, x_lat+SPR_W) & v∈[y_lat, y_lat+SPR_H); compares use 11-bit sums so a sprite at x_lat ≥ 609 clips at column 639 without wrap. `rom_addr` = ((v−y_lat)·SPR_W + (h−x_lat)) truncated to 10 bits, registered; held at 0 when not hit. Ground flag = valid & v==GROUND_Y.
- Stage 3 (S3): `rom_data` valid. Colour priority: not valid → 12'h000; hit & rom_data≠KEY_COLOR → rom_data; ground flag → GROUND_COLOR; else BG_COLOR. Registered into `vga_r/g/b` = bits [11:8]/[7:4]/[3:0].

## Timing
- Latency `h_cnt`→RGB: 3 cycles. `hsync`/`vsync` pass through an identical 3-deep shift register, so sync-to-pixel alignment equals the controller's.
- `rom_addr` registered in S2; ROM output sampled in S3, exactly one cycle later. `rom_addr` is only meaningful for a hit.
- `frame_tick` is high for exactly one `pclk` per frame, 1 cycle after the latch cycle.
- Reset (any time, asynchronous): RGB = 0, `hsync`=`vsync`=1, `frame_tick`=0, `rom_addr`=0, all pipeline valid bits 0, `x_lat`=`y_lat`=0, `pos_ok`=0, sync-edge register = 1 so no spurious tick at release.
- Sprite positions changing mid-frame have no visible effect until the next vsync falling edge.

## Configuration
- `DINO_GROUND_LINE_EN`: defined → ground line drawn at `GROUND_Y` with `GROUND_COLOR` under the sprite. Undefined → ground flag logic is removed and such pixels show `BG_COLOR`; all other behaviour and latency are unchanged.

## Test plan
- Reset mid-line at `h_cnt`=100 → next edge RGB=0, `hsync`=`vsync`=1, `frame_tick` stays 0 at release; no sprite drawn before first vsync fall.
- spr_x=100, spr_y=300, ROM=address value (non-key) → pixel (100,300) outputs ROM[0] 3 cycles after input; (131,331) outputs ROM[1023]; (132,300) outputs 12'hFFF.
- ROM word = 12'hF0F at sprite pixel on row 400 → output 12'h555 with macro, 12'hFFF without.
- spr_x changed 100→200 while v_cnt=240 → current frame still drawn at 100; after vsync fall `frame_tick` pulses once and next frame draws at 200.
- spr_x=620 → columns 620–639 draw sprite cols 0–19, no wrap into columns 0–11 of the following line.
- Sync alignment: `hsync` fall occurs exactly 3 cycles after `hsync_in` fall; RGB=0 whenever delayed valid is 0.
